// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI-Lite command sequencer: response codes, FSM states, command word layout.
// The packed cmd_t is the exact word stored in the command FIFO (write, addr, data, wstrb).
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wstrb;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO, show-ahead read (head visible while o_rd_vld); a pop takes effect on the next edge.
// Writes are refused while full (o_wr_rdy=0); read and write may happen in the same cycle.
module cmd_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 4
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             i_wr_vld,
    output logic             o_wr_rdy,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic             i_rd_en,
    output logic             o_rd_vld,
    output logic [WIDTH-1:0] o_rd_dat
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Extra MSB on each pointer distinguishes full (MSBs differ) from empty (identical).
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_push  = i_wr_vld && !w_full;
    assign w_pop   = i_rd_en && !w_empty;

    assign o_wr_rdy = !w_full;
    assign o_rd_vld = !w_empty;
    assign o_rd_dat = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_dat;
        end
    end

endmodule

// File: rtl/axi_lite_cmd_sequencer.sv
// Buffers register commands and issues them one at a time to an AXI-Lite master; pop-to-start is 1 cycle.
// cmd_ready drops only when the FIFO is full; the response is held until rsp_ready.
module axi_lite_cmd_sequencer
    import axi_lite_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [3:0]  cmd_wstrb,
    output logic        start_read,
    output logic        start_write,
    output logic [31:0] addr,
    output logic [31:0] data,
    output logic [3:0]  wstrb,
    input  logic        bvalid,
    input  logic        bready,
    input  logic [1:0]  bresp,
    input  logic        rvalid,
    input  logic        rready,
    input  logic [1:0]  rresp,
    input  logic [31:0] rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [1:0]  rsp_resp,
    output logic [31:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        busy
);

    localparam int              TW       = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

    cmd_t        w_push_dat;
    cmd_t        w_head;
    logic        w_fifo_rdy;
    logic        w_fifo_vld;
    logic        w_pop;
    logic        w_b_hs;
    logic        w_r_hs;

    seq_state_t  r_state;
    logic        r_op_write;
    logic        r_start_read;
    logic        r_start_write;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_wstrb;
    logic [TW-1:0] r_timer;
    logic        r_rsp_valid;
    logic        r_rsp_write;
    logic [1:0]  r_rsp_resp;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_timeout;

    assign w_push_dat = {cmd_write, cmd_addr, cmd_data, cmd_wstrb};
    assign w_pop      = (r_state == IDLE) && w_fifo_vld;

    // Only the channel matching the in-flight operation can complete it.
    assign w_b_hs = r_op_write  && bvalid && bready;
    assign w_r_hs = !r_op_write && rvalid && rready;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .aclk     (aclk),
        .areset   (areset),
        .i_wr_vld (cmd_valid),
        .o_wr_rdy (w_fifo_rdy),
        .i_wr_dat (w_push_dat),
        .i_rd_en  (w_pop),
        .o_rd_vld (w_fifo_vld),
        .o_rd_dat (w_head)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state       <= IDLE;
            r_op_write    <= 1'b0;
            r_start_read  <= 1'b0;
            r_start_write <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_wstrb       <= '0;
            r_timer       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_write   <= 1'b0;
            r_rsp_resp    <= RESP_OKAY;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fifo_vld) begin
                        r_op_write    <= w_head.write;
                        r_addr        <= w_head.addr;
                        r_data        <= w_head.data;
                        r_wstrb       <= w_head.wstrb;
                        r_start_write <= w_head.write;
                        r_start_read  <= !w_head.write;
                        r_state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_start_write <= 1'b0;
                    r_start_read  <= 1'b0;
                    r_timer       <= '0;
                    r_state       <= WAIT;
                end
                WAIT: begin
                    // Handshake is tested first so it wins a tie with the timeout.
                    if (w_b_hs) begin
                        r_rsp_write   <= 1'b1;
                        r_rsp_resp    <= bresp;
                        r_rsp_rdata   <= '0;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end else if (w_r_hs) begin
                        r_rsp_write   <= 1'b0;
                        r_rsp_resp    <= rresp;
                        r_rsp_rdata   <= rdata;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end else if (r_timer == TMO_LAST) begin
                        r_rsp_write   <= r_op_write;
                        r_rsp_resp    <= RESP_SLVERR;
                        r_rsp_rdata   <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end else if (r_timer != {TW{1'b1}}) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = w_fifo_rdy;
    assign start_read  = r_start_read;
    assign start_write = r_start_write;
    assign addr        = r_addr;
    assign data        = r_data;
    assign wstrb       = r_wstrb;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_write   = r_rsp_write;
    assign rsp_resp    = r_rsp_resp;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_timeout = r_rsp_timeout;
    assign busy        = w_fifo_vld || (r_state != IDLE);

endmodule
